// File: rtl/lsu_ctrl_if.sv
// Bundle of the lsu_ctrl request, response and data-memory signals.
// Handshakes: a transfer happens on a rising Clk edge where valid and ready
// are both 1; valid, once raised, holds its payload stable until that edge.
// The slave modport is the controller's view; master is the view of its
// surroundings (execute stage, response consumer and data memory).
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32
);
  // request from the execute stage
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  // response to the consumer
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  // data memory port
  logic [ADDR_W-1:0] Ad;
  logic [31:0]       WrData;
  logic [2:0]        MemWr;
  logic [1:0]        DMcut_sel;
  logic [31:0]       DM;
  // controller state, for observation only
  logic [1:0]        state_dbg;

  modport slave (
    input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output Ad, WrData, MemWr, DMcut_sel,
    input  DM,
    output state_dbg
  );

  modport master (
    output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  Ad, WrData, MemWr, DMcut_sel,
    output DM,
    input  state_dbg
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller in front of a data memory with a one-cycle
// registered read. One request in flight at a time; loads go
// IDLE->ISSUE->CAPT->RESP, stores IDLE->ISSUE->RESP, rejected requests
// IDLE->RESP. Memory-side and response outputs are all registered.
module lsu_ctrl #(
  parameter int MEM_DEPTH = 64,
  parameter int ADDR_W    = 32
) (
  input logic       Clk,
  input logic       Reset,
  lsu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, next_state;

  // request attributes still needed after the accept cycle
  logic wr_q;
  logic signed_q;

  logic        req_err;
  logic [2:0]  wr_cmd;
  logic [31:0] load_data;

  assign bus.req_ready = (state == IDLE);
  assign bus.state_dbg = state;

  // Classify the incoming request: bad size, misalignment or out of range.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      2'd0:    if (bus.req_addr[1:0] != 2'd0) req_err = 1'b1;
      2'd2:    if (bus.req_addr[0]) req_err = 1'b1;
      2'd3:    req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if (bus.req_addr >= ADDR_W'(MEM_DEPTH)) req_err = 1'b1;
  end

  // Translate the request size into the memory write command code.
  always_comb begin
    wr_cmd = 3'd0;
    case (bus.req_size)
      2'd0:    wr_cmd = 3'd1;
      2'd1:    wr_cmd = 3'd2;
      2'd2:    wr_cmd = 3'd4;
      default: wr_cmd = 3'd0;
    endcase
  end

  // The memory already zero-extends sub-word reads; only sign-fill here.
  always_comb begin
    load_data = bus.DM;
    if (signed_q) begin
      if (bus.DMcut_sel == 2'd1)      load_data = {{24{bus.DM[7]}}, bus.DM[7:0]};
      else if (bus.DMcut_sel == 2'd2) load_data = {{16{bus.DM[15]}}, bus.DM[15:0]};
    end
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.req_valid) next_state = req_err ? RESP : ISSUE;
      ISSUE:   next_state = wr_q ? RESP : CAPT;
      CAPT:    next_state = RESP;
      RESP:    if (bus.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered memory command, response payload and latched request bits.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_q          <= 1'b0;
      signed_q      <= 1'b0;
      bus.Ad        <= '0;
      bus.WrData    <= '0;
      bus.MemWr     <= 3'd0;
      bus.DMcut_sel <= 2'd0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      // a write command lives for exactly one cycle (the ISSUE cycle)
      bus.MemWr <= 3'd0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            wr_q     <= bus.req_wr;
            signed_q <= bus.req_signed;
            if (req_err) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
            end else begin
              bus.Ad        <= bus.req_addr;
              bus.DMcut_sel <= bus.req_size;
              bus.WrData    <= bus.req_wdata;
              if (bus.req_wr) bus.MemWr <= wr_cmd;
            end
          end
        end
        ISSUE: begin
          if (wr_q) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
          end
        end
        CAPT: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= load_data;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
